// File: rtl/scan_decoder_pkg.sv
// ---------------------------------------------------------------------------
// scan_decoder_pkg
// Shared types and constants for the scan decoder.
//   state_t          : FSM state encoding (IDLE, DIRECT, SCAN, GAP)
//   SCAN_GAP_CYCLES  : all-ones cycles inserted between consecutive scan slots
//   GAP_CNT_W        : width of the gap cycle counter
// ---------------------------------------------------------------------------
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int SCAN_GAP_CYCLES = 1;
    localparam int GAP_CNT_W       = 2;

endpackage

// File: rtl/scan_decoder_onecold.sv
// ---------------------------------------------------------------------------
// onecold_dec
// Combinational SEL_W-to-OUT_N decoder with active-low (one-cold) outputs.
//   en   : when low, all outputs are 1 (inactive)
//   sel  : index of the output to pull low
//   y_n  : decoded outputs, active low
// ---------------------------------------------------------------------------
module onecold_dec #(
    parameter int SEL_W = 3,
    parameter int OUT_N = 2**SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_N-1:0] y_n
);

    always_comb begin
        y_n = '1;
        if (en) begin
            y_n[sel] = 1'b0;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
// Registered one-cold decoder with a direct mode and an auto-scan mode.
//   clk, rst_n : clock and synchronous active-low reset
//   en         : enable; low forces all outputs inactive and returns to IDLE
//   mode       : 0 = direct decode of sel, 1 = auto-scan over all outputs
//   sel        : direct-mode code, loaded when sel_valid is high
//   sel_valid  : qualifies sel in direct mode
//   dwell      : scan slot length minus one, sampled at the start of each slot
//   y_n        : registered one-cold outputs, active low
//   cur_sel    : index currently driven low, 0 when none is
//   active     : high when exactly one y_n bit is low
//   wrap       : pulse in the first cycle of slot 0 after slot OUT_N-1
// ---------------------------------------------------------------------------
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int OUT_N   = 2**SEL_W,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sel_valid,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_N-1:0]   y_n,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               active,
    output logic               wrap
);

    state_t               state;
    logic [SEL_W-1:0]     idx;
    logic [DWELL_W-1:0]   cnt;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic                 wrap_pend;

    logic                 dec_en;
    logic [SEL_W-1:0]     dec_sel;
    logic [OUT_N-1:0]     dec_y_n;

    // Decoder input select: the scan index while scanning, sel in direct mode.
    always_comb begin
        dec_en  = 1'b0;
        dec_sel = idx;
        if (en) begin
            case (state)
                SCAN:    dec_en = mode;
                DIRECT: begin
                    if (!mode && sel_valid) begin
                        dec_en  = 1'b1;
                        dec_sel = sel;
                    end
                end
                default: dec_en = 1'b0;
            endcase
        end
    end

    onecold_dec #(
        .SEL_W (SEL_W),
        .OUT_N (OUT_N)
    ) u_dec (
        .en  (dec_en),
        .sel (dec_sel),
        .y_n (dec_y_n)
    );

    // Outputs reflect the state occupied during the previous cycle, so every
    // state entry (from IDLE or a mode change) shows one all-ones cycle first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            wrap_pend <= 1'b0;
            y_n       <= '1;
            cur_sel   <= '0;
            active    <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                idx       <= '0;
                cnt       <= '0;
                gap_cnt   <= '0;
                wrap_pend <= 1'b0;
                y_n       <= '1;
                cur_sel   <= '0;
                active    <= 1'b0;
            end else if ((state == SCAN || state == GAP) && !mode) begin
                state     <= DIRECT;
                idx       <= '0;
                cnt       <= '0;
                gap_cnt   <= '0;
                wrap_pend <= 1'b0;
                y_n       <= '1;
                cur_sel   <= '0;
                active    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        y_n       <= '1;
                        cur_sel   <= '0;
                        active    <= 1'b0;
                        idx       <= '0;
                        wrap_pend <= 1'b0;
                        cnt       <= mode ? dwell : '0;
                        state     <= mode ? SCAN : DIRECT;
                    end
                    DIRECT: begin
                        if (mode) begin
                            state     <= SCAN;
                            idx       <= '0;
                            wrap_pend <= 1'b0;
                            cnt       <= dwell;
                            y_n       <= '1;
                            cur_sel   <= '0;
                            active    <= 1'b0;
                        end else if (sel_valid) begin
                            y_n     <= dec_y_n;
                            cur_sel <= sel;
                            active  <= 1'b1;
                        end
                    end
                    SCAN: begin
                        y_n       <= dec_y_n;
                        cur_sel   <= idx;
                        active    <= 1'b1;
                        wrap      <= wrap_pend;
                        wrap_pend <= 1'b0;
                        if (cnt == '0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_CNT_W'(SCAN_GAP_CYCLES - 1);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    GAP: begin
                        y_n     <= '1;
                        cur_sel <= '0;
                        active  <= 1'b0;
                        if (gap_cnt == '0) begin
                            state     <= SCAN;
                            idx       <= idx + 1'b1;
                            wrap_pend <= (idx == SEL_W'(OUT_N - 1));
                            cnt       <= dwell;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_scan_decoder
// Directed bench for scan_decoder: a SEL_W=3 instance plus SEL_W=2 and
// SEL_W=4 instances sharing the same stimulus for the scan sweep.
// ---------------------------------------------------------------------------
module tb_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n, en, mode, sel_valid;
    logic [2:0]  sel;
    logic [7:0]  dwell;

    logic [7:0]  y_n;
    logic [2:0]  cur_sel;
    logic        active, wrap;
    logic [3:0]  y_n2;
    logic [1:0]  cur_sel2;
    logic        active2, wrap2;
    logic [15:0] y_n4;
    logic [3:0]  cur_sel4;
    logic        active4, wrap4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .dwell(dwell), .y_n(y_n),
        .cur_sel(cur_sel), .active(active), .wrap(wrap)
    );

    scan_decoder #(.SEL_W(2), .DWELL_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[1:0]),
        .sel_valid(sel_valid), .dwell(dwell), .y_n(y_n2),
        .cur_sel(cur_sel2), .active(active2), .wrap(wrap2)
    );

    scan_decoder #(.SEL_W(4), .DWELL_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel({1'b0, sel}),
        .sel_valid(sel_valid), .dwell(dwell), .y_n(y_n4),
        .cur_sel(cur_sel4), .active(active4), .wrap(wrap4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scan model: slot length dw+1 active cycles followed by one gap cycle,
    // k counted from the first active output cycle after scan entry.
    function automatic logic [15:0] exp_y(input int nout, input int dw, input int k);
        int per, pos, mask;
        per  = dw + 2;
        pos  = k % (per * nout);
        mask = (1 << nout) - 1;
        if ((pos % per) <= dw) return 16'(mask & ~(1 << (pos / per)));
        return 16'(mask);
    endfunction

    function automatic int exp_sel(input int nout, input int dw, input int k);
        int per, pos;
        per = dw + 2;
        pos = k % (per * nout);
        return ((pos % per) <= dw) ? (pos / per) : 0;
    endfunction

    function automatic logic exp_act(input int nout, input int dw, input int k);
        int per;
        per = dw + 2;
        return ((k % (per * nout)) % per) <= dw;
    endfunction

    function automatic logic exp_wrap(input int nout, input int dw, input int k);
        return (k > 0) && ((k % ((dw + 2) * nout)) == 0);
    endfunction

    task automatic start_scan(input int dw);
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = 3'd0;
        tick();
        rst_n = 1'b1; en = 1'b1; mode = 1'b1; dwell = 8'(dw);
        tick();
        chk("scan_entry_y", 64'(y_n), 64'hFF);
        chk("scan_entry_act", 64'(active), 64'd0);
    endtask

    task automatic run_scan(input int dw, input int k0, input int k1, input bit sweep);
        for (int k = k0; k <= k1; k++) begin
            sel = 3'(k);           // sel_valid stays high: must be ignored
            tick();
            chk("scan_y", 64'(y_n), 64'(exp_y(8, dw, k)));
            chk("scan_cur", 64'(cur_sel), 64'(exp_sel(8, dw, k)));
            chk("scan_act", 64'(active), 64'(exp_act(8, dw, k)));
            chk("scan_wrap", 64'(wrap), 64'(exp_wrap(8, dw, k)));
            chk("onecold", 64'($countones(~y_n) <= 1), 64'd1);
            if (sweep) begin
                chk("sw2_y", 64'(y_n2), 64'(exp_y(4, dw, k)));
                chk("sw2_cur", 64'(cur_sel2), 64'(exp_sel(4, dw, k)));
                chk("sw2_act", 64'(active2), 64'(exp_act(4, dw, k)));
                chk("sw2_wrap", 64'(wrap2), 64'(exp_wrap(4, dw, k)));
                chk("sw4_y", 64'(y_n4), 64'(exp_y(16, dw, k)));
                chk("sw4_cur", 64'(cur_sel4), 64'(exp_sel(16, dw, k)));
                chk("sw4_act", 64'(active4), 64'(exp_act(16, dw, k)));
                chk("sw4_wrap", 64'(wrap4), 64'(exp_wrap(16, dw, k)));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 3'd0; sel_valid = 1'b0; dwell = 8'd2;

        // Reset takes priority over en/mode
        tick(); tick();
        chk("rst_y", 64'(y_n), 64'hFF);
        chk("rst_cur", 64'(cur_sel), 64'd0);
        chk("rst_act", 64'(active), 64'd0);
        chk("rst_wrap", 64'(wrap), 64'd0);

        // Direct mode
        mode = 1'b0; dwell = 8'd7;
        rst_n = 1'b1;
        tick();
        chk("dir_entry_y", 64'(y_n), 64'hFF);
        tick();
        chk("dir_nosel_y", 64'(y_n), 64'hFF);
        chk("dir_nosel_act", 64'(active), 64'd0);
        sel = 3'd5; sel_valid = 1'b1;
        tick();
        chk("dir5_y", 64'(y_n), 64'hDF);
        chk("dir5_cur", 64'(cur_sel), 64'd5);
        chk("dir5_act", 64'(active), 64'd1);
        sel = 3'd2; sel_valid = 1'b0;
        tick(); tick();
        chk("dir_hold_y", 64'(y_n), 64'hDF);
        chk("dir_hold_cur", 64'(cur_sel), 64'd5);
        sel = 3'd0; sel_valid = 1'b1;
        tick();
        chk("dir0_y", 64'(y_n), 64'hFE);
        sel = 3'd7;
        tick();
        chk("dir7_y", 64'(y_n), 64'h7F);
        chk("dir7_cur", 64'(cur_sel), 64'd7);
        chk("dir_wrap", 64'(wrap), 64'd0);

        // Scan dwell=2, two full periods of the 8-output instance, sweep on
        start_scan(2);
        sel_valid = 1'b1;
        run_scan(2, 0, 63, 1'b1);

        // Boundary dwell=0: 1 active / 1 gap, 16-clock period
        start_scan(0);
        sel_valid = 1'b1;
        run_scan(0, 0, 33, 1'b0);

        // en dropped mid-slot at idx 6, then raised: restart at idx 0
        start_scan(2);
        sel_valid = 1'b0;
        run_scan(2, 0, 24, 1'b0);
        en = 1'b0;
        tick();
        chk("endrop_y", 64'(y_n), 64'hFF);
        chk("endrop_cur", 64'(cur_sel), 64'd0);
        chk("endrop_act", 64'(active), 64'd0);
        en = 1'b1;
        tick();
        chk("enrise_gap_y", 64'(y_n), 64'hFF);
        tick();
        chk("enrise_y", 64'(y_n), 64'hFE);
        chk("enrise_cur", 64'(cur_sel), 64'd0);
        chk("enrise_act", 64'(active), 64'd1);

        // mode 1->0 at idx 3
        start_scan(2);
        sel_valid = 1'b0;
        run_scan(2, 0, 12, 1'b0);
        mode = 1'b0;
        tick();
        chk("m10_y", 64'(y_n), 64'hFF);
        chk("m10_act", 64'(active), 64'd0);
        tick();
        chk("m10_dir_y", 64'(y_n), 64'hFF);
        sel = 3'd0; sel_valid = 1'b1;
        tick();
        chk("m10_sel0_y", 64'(y_n), 64'hFE);
        chk("m10_sel0_act", 64'(active), 64'd1);

        // dwell change mid-slot takes effect from the next slot
        start_scan(2);
        sel_valid = 1'b0;
        run_scan(2, 0, 1, 1'b0);
        dwell = 8'd0;
        tick(); chk("dwchg_k2", 64'(y_n), 64'hFE);
        tick(); chk("dwchg_k3", 64'(y_n), 64'hFF);
        tick(); chk("dwchg_k4", 64'(y_n), 64'hFD);
        tick(); chk("dwchg_k5", 64'(y_n), 64'hFF);
        tick(); chk("dwchg_k6", 64'(y_n), 64'hFB);

        // Reset mid-slot
        start_scan(2);
        run_scan(2, 0, 5, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("midrst_y", 64'(y_n), 64'hFF);
        chk("midrst_cur", 64'(cur_sel), 64'd0);
        chk("midrst_act", 64'(active), 64'd0);
        chk("midrst_wrap", 64'(wrap), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("postrst_y1", 64'(y_n), 64'hFF);
        tick();
        chk("postrst_y2", 64'(y_n), 64'hFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter SEL_W, default 3: width of the select code.
REQ-002 Parameter OUT_N, default 2**SEL_W: number of decoded outputs, fixed to 2**SEL_W.
REQ-003 Parameter DWELL_W, default 8: width of the dwell field.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 en  input  1  active-high enable; low forces all outputs inactive.
REQ-007 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 sel  input  SEL_W  code to decode in direct mode.
REQ-009 sel_valid  input  1  qualifies sel in direct mode.
REQ-010 dwell  input  DWELL_W  active cycles per scan slot, minus 1.
REQ-011 y_n  output  OUT_N  registered one-cold decoded outputs, active low.
REQ-012 cur_sel  output  SEL_W  index of the output currently driven low; 0 when none is.
REQ-013 active  output  1  high when exactly one y_n bit is low.
REQ-014 wrap  output  1  one-cycle pulse in the cycle scan re-enters index 0 after index OUT_N-1.

Function
REQ-015 All outputs shall be registered; no combinational path shall exist from any input to any output.
REQ-016 FSM states shall be IDLE, DIRECT, SCAN and GAP.
REQ-017 IDLE: y_n all ones, active=0, wrap=0; the FSM shall go to DIRECT when en=1 and mode=0, and to SCAN at index 0 when en=1 and mode=1.
REQ-018 DIRECT: a cycle with sel_valid=1 shall load y_n[sel]=0 and all other bits 1, with latency 1 cycle; without sel_valid, y_n shall hold its value.
REQ-019 DIRECT before the first sel_valid: y_n shall be all ones and active=0.
REQ-020 SCAN: y_n[idx]=0 and all other bits 1 for exactly dwell+1 cycles; dwell=0 gives a 1-cycle slot.
REQ-021 dwell shall be sampled on entry to each slot; changes mid-slot shall take effect from the next slot.
REQ-022 GAP: one cycle of all ones between consecutive slots (break-before-make); no two y_n bits shall ever be low together, including across a GAP.
REQ-023 After GAP, idx shall advance by 1 modulo OUT_N; idx OUT_N-1 shall wrap to 0 and assert wrap in the first cycle of slot 0.
REQ-024 en=0 in any state: next cycle IDLE, y_n all ones, idx cleared to 0, dwell counter cleared.
REQ-025 A mode change while en=1 shall take effect next cycle: y_n all ones for one cycle, then the new mode starts; a scan always restarts at idx 0.
REQ-026 sel_valid shall be ignored in SCAN and GAP; dwell shall be ignored in DIRECT.
REQ-027 The dwell counter shall be DWELL_W bits, count down from the sampled dwell to 0, and never underflow.

Reset
REQ-028 With rst_n=0 at a clock edge: state=IDLE, y_n all ones, cur_sel=0, active=0, wrap=0, idx=0, dwell counter=0.
REQ-029 Reset shall take priority over en and mode; asserting reset mid-slot or mid-GAP shall produce the reset values next cycle.
REQ-030 After release, the first active output shall appear no earlier than the 2nd rising edge.

Structure
REQ-031 Package scan_decoder_pkg shall hold the FSM state enum and a constant SCAN_GAP_CYCLES = 1.
REQ-032 There shall be one sub-module, onecold_dec: a parametrised SEL_W-to-OUT_N active-low combinational decoder with enable, instantiated once, output registered in the parent.

Verification
REQ-033 Direct: SEL_W=3, en=1, mode=0, sel=5 with sel_valid for 1 cycle -> next cycle y_n=8'b1101_1111, cur_sel=5, active=1; held while sel_valid=0.
REQ-034 Scan: dwell=2, mode=1 -> y_n[0] low 3 cycles, 1 GAP cycle, y_n[1] low 3 cycles, ...; wrap high only in the first cycle of each return to idx 0; period 32 cycles.
REQ-035 Boundary: dwell=0 -> alternating 1 active / 1 gap cycle; a full cycle is 16 clocks; the bench asserts no cycle with two or more y_n bits low.
REQ-036 en dropped mid-slot at idx 6 -> next cycle y_n=8'hFF, cur_sel=0; en raised again -> scan resumes at idx 0.
REQ-037 mode switched 1->0 at idx 3 -> one all-ones cycle, then DIRECT with y_n=8'hFF until sel_valid; sel=0 -> y_n=8'b1111_1110.
REQ-038 rst_n=0 for 1 cycle during a SCAN slot -> reset values next edge; a parameter sweep with SEL_W=2 and SEL_W=4 repeats REQ-034.
